// File: rtl/clkgate_ctrl_if.sv
// Signal bundle between the clock-gating controller and the unit it gates.
// Latency: none; this is wiring only.
// Backpressure: Ready tells upstream when work may be issued.
// Ports: Activity/ForceOn/CountClr flow into the controller;
//        GateEn/Ready/GatedCount flow out of it.
interface clkgate_ctrl_if;
  logic        Activity;
  logic        ForceOn;
  logic        CountClr;
  logic        GateEn;
  logic        Ready;
  logic [15:0] GatedCount;

  // master drives the requests and observes the gate status.
  modport master (
    output Activity, ForceOn, CountClr,
    input  GateEn, Ready, GatedCount
  );

  // slave is the controller itself.
  modport slave (
    input  Activity, ForceOn, CountClr,
    output GateEn, Ready, GatedCount
  );
endinterface

// File: rtl/clkgate_ctrl.sv
// Idle-detect clock-gate controller: gates after IDLE_CYCLES idle cycles, wakes on demand.
// Latency: GateEn drops 1 cycle after the last idle cycle; Ready returns WAKE_CYCLES+1 cycles after wake.
// Backpressure: Ready low while gated or settling; upstream must hold off issuing work.
// Ports: clk (free-running), reset (async, active-high), bus (slave modport):
//        Activity/ForceOn in, CountClr in, GateEn/Ready/GatedCount out (all outputs registered).
module clkgate_ctrl #(
  parameter int IDLE_CYCLES = 8,  // 1..255
  parameter int WAKE_CYCLES = 2   // 1..15
) (
  input  logic          clk,
  input  logic          reset,
  clkgate_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic [3:0]  wake_cnt_q, wake_cnt_d;
  logic        gate_en_q, gate_en_d;
  logic        ready_q, ready_d;
  logic [15:0] gated_count_q, gated_count_d;

  logic idle;

  assign idle = ~bus.Activity & ~bus.ForceOn;

  always_comb begin
    state_d       = state_q;
    idle_cnt_d    = idle_cnt_q;
    wake_cnt_d    = wake_cnt_q;
    gated_count_d = gated_count_q;

    case (state_q)
      RUN: begin
        if (!idle) begin
          idle_cnt_d = 8'd0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          // This cycle completes the idle window.
          state_d    = GATED;
          idle_cnt_d = 8'd0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      GATED: begin
        if (!idle) begin
          state_d    = WAKE;
          wake_cnt_d = 4'd0;
        end
      end
      WAKE: begin
        // Settling runs to completion regardless of demand; never re-gates from here.
        wake_cnt_d = wake_cnt_q + 4'd1;
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = RUN;
          idle_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d    = RUN;
        idle_cnt_d = 8'd0;
      end
    endcase

    if (bus.CountClr) begin
      gated_count_d = 16'd0;
    end else if (state_q == GATED && gated_count_q != 16'hFFFF) begin
      gated_count_d = gated_count_q + 16'd1;
    end

    // Outputs are decoded from the next state so the flops present them
    // in the same cycle as the state they describe.
    gate_en_d = (state_d != GATED);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      idle_cnt_q    <= 8'd0;
      wake_cnt_q    <= 4'd0;
      gate_en_q     <= 1'b1;
      ready_q       <= 1'b1;
      gated_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      wake_cnt_q    <= wake_cnt_d;
      gate_en_q     <= gate_en_d;
      ready_q       <= ready_d;
      gated_count_q <= gated_count_d;
    end
  end

  assign bus.GateEn     = gate_en_q;
  assign bus.Ready      = ready_q;
  assign bus.GatedCount = gated_count_q;

endmodule

// File: doc/clkgate_ctrl.md
CLKGATE_CTRL -- requirements
Module: clkgate_ctrl

Interface
REQ-001 Parameter IDLE_CYCLES, default 8, legal 1..255: consecutive idle cycles required before the clock is gated.
REQ-002 Parameter WAKE_CYCLES, default 2, legal 1..15: settle cycles after re-enable before Ready asserts.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  free-running clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 Activity  in  1  the gated unit has pending or in-flight work this cycle.
REQ-007 ForceOn  in  1  debug/test override that holds the clock enabled.
REQ-008 CountClr  in  1  synchronous clear of GatedCount.
REQ-009 GateEn  out  1  enable for the downstream clock-gate cell E input.
REQ-010 Ready  out  1  gated clock is running and settled; upstream may issue work.
REQ-011 GatedCount  out  16  saturating count of cycles spent in GATED.

Function
REQ-012 GateEn, Ready and GatedCount SHALL be driven directly from flops, with no combinational path from inputs, so GateEn is glitch-free at the gate latch.
REQ-013 The FSM SHALL have exactly three states: RUN (GateEn=1, Ready=1), GATED (GateEn=0, Ready=0) and WAKE (GateEn=1, Ready=0).
REQ-014 Idle condition: Idle = ~Activity & ~ForceOn.
REQ-015 RUN, Idle=1: the 8-bit idle counter SHALL increment; Idle=0: it SHALL clear to 0 on that edge.
REQ-016 RUN SHALL transition to GATED on the edge ending the IDLE_CYCLES-th consecutive Idle cycle, so GateEn falls one cycle after that cycle; the idle counter SHALL clear on entry.
REQ-017 If Activity or ForceOn is 1 in the cycle that would reach the threshold, the FSM SHALL remain in RUN and the idle counter SHALL clear.
REQ-018 GATED, Idle=0: the FSM SHALL go to WAKE, with GateEn=1 in the next cycle and the 4-bit wake counter loaded with 0.
REQ-019 WAKE: the wake counter SHALL increment each cycle regardless of Activity; after WAKE_CYCLES cycles in WAKE the FSM SHALL enter RUN with Ready=1.
REQ-020 WAKE SHALL never transition directly to GATED, even if Idle=1 throughout WAKE.
REQ-021 On entry to RUN from WAKE the idle counter SHALL be 0, restarting the full IDLE_CYCLES window.
REQ-022 GatedCount SHALL increment by 1 for each cycle the registered state is GATED and SHALL saturate at 0xFFFF without wrapping.
REQ-023 If CountClr=1, GatedCount SHALL become 0 on that edge; clear wins over a simultaneous increment.
REQ-024 ForceOn=1 in any state SHALL prevent entry to GATED; in GATED it SHALL trigger WAKE exactly as Activity does.
REQ-025 Wake latency from Activity rising in GATED to Ready=1 SHALL be exactly WAKE_CYCLES+1 cycles.

Reset
REQ-026 Asserting reset SHALL immediately, without waiting for clk, force state=RUN, GateEn=1, Ready=1, idle counter=0, wake counter=0 and GatedCount=0.
REQ-027 Reset asserted in GATED or WAKE SHALL raise GateEn asynchronously, so the downstream clock resumes under reset.
REQ-028 After reset deasserts, the first state update SHALL occur on the next rising clk edge.

Verification (IDLE_CYCLES=4, WAKE_CYCLES=2)
REQ-029 Reset, then Activity=0 and ForceOn=0 held -> GateEn=1 for cycles 0-3, GateEn=0 and Ready=0 from cycle 4, and GatedCount increments 1,2,3... from cycle 5.
REQ-030 Idle for 3 cycles, then Activity=1 for 1 cycle, then idle -> no gating until 4 further idle cycles complete.
REQ-031 In GATED, Activity pulse of 1 cycle at cycle T -> GateEn=1 at T+1, Ready=0 at T+1 and T+2, Ready=1 at T+3, and no re-gate before T+7.
REQ-032 GatedCount preset to 0xFFFE while held in GATED -> value 0xFFFF held; CountClr=1 on the same edge as an increment -> 0.
REQ-033 ForceOn=1 with Activity=0 held for 100 cycles -> GateEn=1 throughout; ForceOn falls -> gating after 4 idle cycles.
REQ-034 Reset asserted asynchronously mid-GATED between clk edges -> GateEn=1 and Ready=1 before the next clk edge, and GatedCount=0.
